// File: rtl/mul_div_pkg.sv
// Shared types and constants for the multiply/divide unit.
package mul_div_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StFix
    } md_state_e;

    localparam int unsigned MD_MUL   = 0;
    localparam int unsigned MD_DIV   = 1;
    localparam int unsigned MD_SIGN  = 2;
    localparam int unsigned DIV_ITER = 32;

    // Magnitude of v when interpreted as signed (sgn = 1), else v unchanged.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [31:0] neg32_if(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mul_div_divider.sv
// Iterative radix-2 restoring divider on magnitudes; signs and divide-by-zero
// are resolved on the outputs so the FIX cycle can write them directly.
module mul_div_divider
    import mul_div_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        step_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        last_o,
    output logic [31:0] quo_o,
    output logic [31:0] rem_o
);

    logic [31:0] dividend_q, dividend_d;
    logic [31:0] div_mag_q, div_mag_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic        div0_q, div0_d;

    logic [32:0] rem_shift;
    logic [32:0] diff;

    assign rem_shift = {rem_q, quo_q[31]};
    assign diff      = rem_shift - {1'b0, div_mag_q};

    always_comb begin
        dividend_d = dividend_q;
        div_mag_d  = div_mag_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        div0_d     = div0_q;
        if (load_i) begin
            dividend_d = dividend_i;
            div_mag_d  = mag32(divisor_i, signed_i);
            rem_d      = 32'd0;
            quo_d      = mag32(dividend_i, signed_i);
            cnt_d      = 5'd0;
            q_neg_d    = signed_i && (dividend_i[31] ^ divisor_i[31]);
            r_neg_d    = signed_i && dividend_i[31];
            div0_d     = (divisor_i == 32'd0);
        end else if (step_i) begin
            // Quotient bits shift in from the bottom as dividend bits shift out the top.
            if (!diff[32]) begin
                rem_d = diff[31:0];
                quo_d = {quo_q[30:0], 1'b1};
            end else begin
                rem_d = rem_shift[31:0];
                quo_d = {quo_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dividend_q <= 32'd0;
            div_mag_q  <= 32'd0;
            rem_q      <= 32'd0;
            quo_q      <= 32'd0;
            cnt_q      <= 5'd0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            div0_q     <= 1'b0;
        end else begin
            dividend_q <= dividend_d;
            div_mag_q  <= div_mag_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            div0_q     <= div0_d;
        end
    end

    assign last_o = (cnt_q == 5'(DIV_ITER - 1));
    assign quo_o  = div0_q ? 32'hFFFF_FFFF : neg32_if(quo_q, q_neg_q);
    assign rem_o  = div0_q ? dividend_q : neg32_if(rem_q, r_neg_q);

endmodule

// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit: control FSM, multiplier and HI/LO registers.
// Define MUL_DIV_MUL_PIPE_EN for a two-stage registered multiplier.
module mul_div_unit
    import mul_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst_p,
    input  logic        cancel,
    input  logic [2:0]  mul_div,
    input  logic [1:0]  mt_hi_lo,
    input  logic [31:0] rf_A,
    input  logic [31:0] rf_B,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    md_state_e   state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic [31:0] op_a_q, op_b_q;
    logic        op_sgn_q;

    logic        mul_req, div_req;
    logic        mul_load, div_load, div_step;
    logic        mul_last;
    logic [63:0] product;
    logic        div_last;
    logic [31:0] div_quo, div_rem;

    // Both op bits set is not a legal request.
    assign mul_req = mul_div[MD_MUL] && !mul_div[MD_DIV];
    assign div_req = mul_div[MD_DIV] && !mul_div[MD_MUL];

`ifdef MUL_DIV_MUL_PIPE_EN
    logic        mul_stage_q;
    logic [47:0] pp0_q, pp1_q;
    logic        pp_neg_q;
    logic [31:0] a_mag, b_mag;
    logic [63:0] pp_sum;

    assign a_mag  = mag32(op_a_q, op_sgn_q);
    assign b_mag  = mag32(op_b_q, op_sgn_q);
    assign pp_sum = {16'd0, pp0_q} + {pp1_q, 16'd0};
    assign product = pp_neg_q ? (~pp_sum + 64'd1) : pp_sum;
    assign mul_last = mul_stage_q;

    always_ff @(posedge clk) begin
        if (rst_p) begin
            mul_stage_q <= 1'b0;
            pp0_q       <= 48'd0;
            pp1_q       <= 48'd0;
            pp_neg_q    <= 1'b0;
        end else begin
            mul_stage_q <= (state_q == StMul) && !mul_stage_q && !cancel;
            if ((state_q == StMul) && !mul_stage_q) begin
                pp0_q    <= {16'd0, a_mag} * {32'd0, b_mag[15:0]};
                pp1_q    <= {16'd0, a_mag} * {32'd0, b_mag[31:16]};
                pp_neg_q <= op_sgn_q && (op_a_q[31] ^ op_b_q[31]);
            end
        end
    end
`else
    logic [63:0] a_ext, b_ext;

    // Low 64 bits of the extended product are exact for both signednesses.
    assign a_ext    = {{32{op_sgn_q & op_a_q[31]}}, op_a_q};
    assign b_ext    = {{32{op_sgn_q & op_b_q[31]}}, op_b_q};
    assign product  = a_ext * b_ext;
    assign mul_last = 1'b1;
`endif

    mul_div_divider u_divider (
        .clk_i      (clk),
        .rst_i      (rst_p),
        .load_i     (div_load),
        .step_i     (div_step),
        .signed_i   (mul_div[MD_SIGN]),
        .dividend_i (rf_A),
        .divisor_i  (rf_B),
        .last_o     (div_last),
        .quo_o      (div_quo),
        .rem_o      (div_rem)
    );

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        mul_load = 1'b0;
        div_load = 1'b0;
        div_step = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!cancel) begin
                    if (mul_req) begin
                        mul_load = 1'b1;
                        state_d  = StMul;
                    end else if (div_req) begin
                        div_load = 1'b1;
                        state_d  = StDiv;
                    end else begin
                        if (mt_hi_lo[1]) hi_d = rf_A;
                        if (mt_hi_lo[0]) lo_d = rf_A;
                    end
                end
            end
            StMul: begin
                if (cancel) begin
                    state_d = StIdle;
                end else if (mul_last) begin
                    hi_d    = product[63:32];
                    lo_d    = product[31:0];
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            StDiv: begin
                if (cancel) begin
                    state_d = StIdle;
                end else begin
                    div_step = 1'b1;
                    if (div_last) state_d = StFix;
                end
            end
            StFix: begin
                state_d = StIdle;
                if (!cancel) begin
                    hi_d   = div_rem;
                    lo_d   = div_quo;
                    done_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            state_q  <= StIdle;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
            op_a_q   <= 32'd0;
            op_b_q   <= 32'd0;
            op_sgn_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            if (mul_load) begin
                op_a_q   <= rf_A;
                op_b_q   <= rf_B;
                op_sgn_q <= mul_div[MD_SIGN];
            end
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != StIdle);
    assign done = done_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
module tb_mul_div_unit;

`ifdef MUL_DIV_MUL_PIPE_EN
    localparam int MulBusy = 2;
`else
    localparam int MulBusy = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_p;
    logic        cancel;
    logic [2:0]  mul_div;
    logic [1:0]  mt_hi_lo;
    logic [31:0] rf_A, rf_B;
    logic [31:0] hi, lo;
    logic        busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mul_div_unit dut (
        .clk      (clk),
        .rst_p    (rst_p),
        .cancel   (cancel),
        .mul_div  (mul_div),
        .mt_hi_lo (mt_hi_lo),
        .rf_A     (rf_A),
        .rf_B     (rf_B),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op for a single cycle, then observe a bounded 40-cycle window.
    task automatic run_op(input string tag, input logic [2:0] md, input logic [31:0] a,
                          input logic [31:0] b, input int exp_busy,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int nb, nd;
        nb = 0;
        nd = 0;
        mul_div = md;
        rf_A    = a;
        rf_B    = b;
        @(negedge clk);
        mul_div = 3'b000;
        rf_A    = 32'd0;
        rf_B    = 32'd0;
        for (int i = 0; i < 40; i++) begin
            if (busy) nb++;
            if (done) nd++;
            @(negedge clk);
        end
        check_eq({tag, " busy"}, 64'(nb), 64'(exp_busy));
        check_eq({tag, " done"}, 64'(nd), 64'd1);
        check_eq({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check_eq({tag, " lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        int nb, nd;
        rst_p    = 1'b1;
        cancel   = 1'b0;
        mul_div  = 3'b000;
        mt_hi_lo = 2'b00;
        rf_A     = 32'd0;
        rf_B     = 32'd0;
        repeat (3) @(negedge clk);
        check_eq("rst hi", 64'(hi), 64'd0);
        check_eq("rst lo", 64'(lo), 64'd0);
        check_eq("rst busy", 64'(busy), 64'd0);
        check_eq("rst done", 64'(done), 64'd0);
        rst_p = 1'b0;
        @(negedge clk);

        run_op("umul", 3'b001, 32'hFFFF_FFFF, 32'h2, MulBusy, 32'h1, 32'hFFFF_FFFE);
        run_op("smul", 3'b101, 32'hFFFF_FFFF, 32'h2, MulBusy, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("smul2", 3'b101, 32'hFFFF_FFFD, 32'h5, MulBusy, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("sdiv", 3'b110, 32'hFFFF_FFF9, 32'h2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("sdiv2", 3'b110, 32'h7, 32'hFFFF_FFFE, 33, 32'h1, 32'hFFFF_FFFD);
        run_op("udiv", 3'b010, 32'd100, 32'd7, 33, 32'd2, 32'd14);
        run_op("udiv0", 3'b010, 32'd100, 32'd0, 33, 32'd100, 32'hFFFF_FFFF);
        run_op("sdiv0", 3'b110, 32'hFFFF_FFFB, 32'd0, 33, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_op("sdivovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000);

        // mthi while idle
        mt_hi_lo = 2'b10;
        rf_A     = 32'h1234;
        @(negedge clk);
        mt_hi_lo = 2'b00;
        check_eq("mthi hi", 64'(hi), 64'h1234);
        check_eq("mthi lo", 64'(lo), 64'h8000_0000);

        // mul and mt together: mt dropped, mul result written
        mul_div  = 3'b001;
        mt_hi_lo = 2'b11;
        rf_A     = 32'd3;
        rf_B     = 32'd5;
        @(negedge clk);
        mul_div  = 3'b000;
        mt_hi_lo = 2'b00;
        check_eq("mul+mt hi held", 64'(hi), 64'h1234);
        repeat (4) @(negedge clk);
        check_eq("mul+mt hi", 64'(hi), 64'd0);
        check_eq("mul+mt lo", 64'(lo), 64'd15);

        // mtlo and a new start during a div are ignored
        nb = 0;
        nd = 0;
        mul_div = 3'b010;
        rf_A    = 32'd20;
        rf_B    = 32'd6;
        @(negedge clk);
        mul_div = 3'b000;
        for (int i = 0; i < 40; i++) begin
            if (i == 3) begin
                mt_hi_lo = 2'b01;
                mul_div  = 3'b001;
                rf_A     = 32'hDEAD;
            end else begin
                mt_hi_lo = 2'b00;
                mul_div  = 3'b000;
            end
            if (busy) nb++;
            if (done) nd++;
            @(negedge clk);
        end
        check_eq("div+mt busy", 64'(nb), 64'd33);
        check_eq("div+mt done", 64'(nd), 64'd1);
        check_eq("div+mt hi", 64'(hi), 64'd2);
        check_eq("div+mt lo", 64'(lo), 64'd3);

        // cancel in iteration 10
        mt_hi_lo = 2'b11;
        rf_A     = 32'hAAAA_5555;
        @(negedge clk);
        mt_hi_lo = 2'b00;
        mul_div  = 3'b010;
        rf_A     = 32'd50;
        rf_B     = 32'd3;
        @(negedge clk);
        mul_div = 3'b000;
        repeat (10) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check_eq("cancel busy", 64'(busy), 64'd0);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) nd++;
            @(negedge clk);
        end
        check_eq("cancel done", 64'(nd), 64'd0);
        check_eq("cancel hi", 64'(hi), 64'hAAAA_5555);
        check_eq("cancel lo", 64'(lo), 64'hAAAA_5555);

        // cancel in idle suppresses start and mt
        cancel   = 1'b1;
        mul_div  = 3'b001;
        mt_hi_lo = 2'b11;
        rf_A     = 32'd9;
        rf_B     = 32'd9;
        @(negedge clk);
        cancel   = 1'b0;
        mul_div  = 3'b000;
        mt_hi_lo = 2'b00;
        check_eq("idle cancel busy", 64'(busy), 64'd0);
        check_eq("idle cancel hi", 64'(hi), 64'hAAAA_5555);

        // both op bits set is no request
        mul_div = 3'b011;
        @(negedge clk);
        mul_div = 3'b000;
        check_eq("md 011 busy", 64'(busy), 64'd0);

        // reset during div
        mul_div = 3'b010;
        rf_A    = 32'd77;
        rf_B    = 32'd5;
        @(negedge clk);
        mul_div = 3'b000;
        repeat (5) @(negedge clk);
        rst_p = 1'b1;
        @(negedge clk);
        rst_p = 1'b0;
        check_eq("rstdiv hi", 64'(hi), 64'd0);
        check_eq("rstdiv lo", 64'(lo), 64'd0);
        check_eq("rstdiv busy", 64'(busy), 64'd0);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) nd++;
            @(negedge clk);
        end
        check_eq("rstdiv done", 64'(nd), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 rst_p  in  1  reset, synchronous, active-high.
REQ-003 cancel  in  1  pipeline flush (exception/eret); aborts any in-flight operation.
REQ-004 mul_div  in  3  start request from the EX stage, valid only in the cycle the instruction leaves EX; bit0 = multiply, bit1 = divide, bit2 = signed; 3'b000 = no request.
REQ-005 mt_hi_lo  in  2  move-to request; bit1 = write HI, bit0 = write LO.
REQ-006 rf_A  in  32  multiplicand / dividend / mthi-mtlo data.
REQ-007 rf_B  in  32  multiplier / divisor.
REQ-008 hi  out  32  current HI register.
REQ-009 lo  out  32  current LO register.
REQ-010 busy  out  1  operation in flight; EX SHALL stall any mf/mt/mul_div instruction while high.
REQ-011 done  out  1  one-cycle pulse in the cycle after HI/LO receive a result.

Function
REQ-012 FSM states: IDLE, MUL, DIV, FIX; busy = (state != IDLE).
REQ-013 IDLE with mul_div[0] = 1: latch operands, go to MUL; mul_div[1] = 1: latch operands, go to DIV; bit0 and bit1 both set: treat as no request.
REQ-014 Multiply: 64-bit product of the 32-bit operands (signed if bit2, else unsigned); HI = product[63:32], LO = product[31:0].
REQ-015 MUL latency is set by REQ-027/028; on the final MUL cycle write HI/LO and return to IDLE.
REQ-016 Divide: radix-2 restoring on magnitudes, 32 iteration cycles in DIV (5-bit counter, 0..31), then one FIX cycle.
REQ-017 FIX applies signs and writes HI/LO, then goes to IDLE; busy is high for exactly 33 cycles after the start edge.
REQ-018 Signed divide sign rules: quotient negative iff operand signs differ; remainder takes the dividend's sign; LO = quotient, HI = remainder.
REQ-019 Divide by zero: LO = 32'hFFFFFFFF, HI = rf_A (the latched dividend), signed or unsigned; no exception is raised.
REQ-020 Signed 32'h80000000 / 32'hFFFFFFFF: LO = 32'h80000000, HI = 0.
REQ-021 mt_hi_lo in IDLE: write rf_A to the selected register(s) at the next edge; mt_hi_lo and a start in the same cycle: the start wins and the mt write is dropped.
REQ-022 mul_div or mt_hi_lo asserted while busy: ignored.
REQ-023 cancel while busy: go to IDLE next edge; HI/LO unchanged; no done pulse. cancel in IDLE also suppresses a same-cycle start or mt write.
REQ-024 hi and lo are plain register outputs; a result becomes visible the cycle after the writing edge, and done is asserted in that same cycle.

Reset
REQ-025 rst_p has priority over every other input: state = IDLE, hi = 0, lo = 0, busy = 0, done = 0, counter = 0.
REQ-026 rst_p asserted mid-operation discards the operation; no done pulse follows.

Configuration
REQ-027 MUL_DIV_MUL_PIPE_EN defined: the multiply is split into two registered stages (partial products, then sum); MUL lasts 2 cycles and busy is high for 2 cycles.
REQ-028 MUL_DIV_MUL_PIPE_EN undefined: single-cycle combinational product; MUL lasts 1 cycle and busy is high for 1 cycle. The divide path is identical in both builds.

Structure
REQ-029 The shared package holds the FSM state encoding, the mul_div bit-index constants (MD_MUL = 0, MD_DIV = 1, MD_SIGN = 2) and the DIV_ITER = 32 constant.
REQ-030 One sub-module, mul_div_divider, contains the iterative divider datapath (magnitudes, partial remainder, quotient shift, counter); the FSM, multiplier and HI/LO registers stay in mul_div_unit.

Verification
REQ-031 Unsigned mult 32'hFFFFFFFF x 32'h2 -> hi = 1, lo = 32'hFFFFFFFE; busy high for 1 cycle (2 cycles with MUL_DIV_MUL_PIPE_EN).
REQ-032 Signed div -7 / 2 -> lo = 32'hFFFFFFFD, hi = 32'hFFFFFFFF; busy high exactly 33 cycles; done pulses once.
REQ-033 Unsigned div 100 / 0 -> lo = 32'hFFFFFFFF, hi = 100; signed 32'h80000000 / -1 -> lo = 32'h80000000, hi = 0.
REQ-034 Start a div, assert cancel in iteration 10 -> IDLE next cycle, hi/lo keep prior values, no done pulse.
REQ-035 mthi with rf_A = 32'h1234 while idle -> hi = 32'h1234; mtlo during a div -> ignored; mul and mt in the same cycle -> only the mul result is written.
REQ-036 Assert rst_p during DIV -> hi = lo = 0, busy = 0 the next cycle, no done pulse.
